// File: rtl/sext_narrow_stream_if.sv
// Stream bus for sext_narrow_stream: 32-bit words in, 8-bit narrowed words plus overflow flag out.
interface sext_narrow_stream_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] din;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  dout;
  logic        out_ovf;

  modport master (
    output in_valid, din, out_ready,
    input  in_ready, out_valid, dout, out_ovf
  );

  modport slave (
    input  in_valid, din, out_ready,
    output in_ready, out_valid, dout, out_ovf
  );
endinterface

// File: rtl/sext_narrow_stream.sv
// Narrows sign-extended 32-bit words to 8 bits through a 2-entry skid FIFO, flagging and counting overflows.
// Optional build macro NARROW_SATURATE_EN: overflowing words saturate to 0x7F/0x80 instead of truncating.
module sext_narrow_stream #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  sext_narrow_stream_if.slave bus,
  input  logic             clr_count,
  output logic [CNT_W-1:0] ovf_count
);

  logic [1:0] count, count_nxt;
  logic       rdy_q;
  logic [7:0] head_val, skid_val, in_val;
  logic       head_ovf, skid_ovf, in_ovf;
  logic       push, pop;

  assign in_ovf = (bus.din[31:8] != {24{bus.din[7]}});

`ifdef NARROW_SATURATE_EN
  // Saturation sign comes from the true MSB, not from the corrupted bit 7.
  assign in_val = in_ovf ? (bus.din[31] ? 8'h80 : 8'h7F) : bus.din[7:0];
`else
  assign in_val = bus.din[7:0];
`endif

  assign push = bus.in_valid & rdy_q;
  assign pop  = bus.out_valid & bus.out_ready;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = (count != 2'd0);
  assign bus.dout      = head_val;
  assign bus.out_ovf   = head_ovf;

  // Head is its own register so dout holds its last value when the FIFO drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= 2'd0;
      rdy_q    <= 1'b1;
      head_val <= 8'h00;
      head_ovf <= 1'b0;
      skid_val <= 8'h00;
      skid_ovf <= 1'b0;
    end else begin
      count <= count_nxt;
      rdy_q <= (count_nxt != 2'd2);
      if (pop && count == 2'd2) begin
        head_val <= skid_val;
        head_ovf <= skid_ovf;
      end else if (push && (count == 2'd0 || pop)) begin
        head_val <= in_val;
        head_ovf <= in_ovf;
      end
      if (push && count == 2'd1 && !pop) begin
        skid_val <= in_val;
        skid_ovf <= in_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      ovf_count <= '0;
    else if (clr_count)
      ovf_count <= '0;
    else if (push && in_ovf && !(&ovf_count))
      ovf_count <= ovf_count + 1'b1;
  end

endmodule

// File: tb/tb_sext_narrow_stream.sv
// Directed bench for sext_narrow_stream: vector table plus backpressure, reset and counter-clear sequences.
module tb_sext_narrow_stream;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset;
  logic clr_count;
  logic [CNT_W-1:0] ovf_count;

  sext_narrow_stream_if bus();

  sext_narrow_stream #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus), .clr_count(clr_count), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] din;
    logic [7:0]  exp_dout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ovf_val(input logic [31:0] d);
`ifdef NARROW_SATURATE_EN
    return d[31] ? 8'h80 : 8'h7F;
`else
    return d[7:0];
`endif
  endfunction

  initial begin
    int exp_cnt;
    vecs[0] = '{32'hFFFFFF80, 8'h80, 1'b0};
    vecs[1] = '{32'h0000007F, 8'h7F, 1'b0};
    vecs[2] = '{32'h00000080, ovf_val(32'h00000080), 1'b1};
    vecs[3] = '{32'hFFFFFF7F, ovf_val(32'hFFFFFF7F), 1'b1};
    vecs[4] = '{32'h00000000, 8'h00, 1'b0};
    vecs[5] = '{32'hFFFFFFFF, 8'hFF, 1'b0};
    vecs[6] = '{32'h12345678, ovf_val(32'h12345678), 1'b1};
    vecs[7] = '{32'h80000001, ovf_val(32'h80000001), 1'b1};
    vecs[8] = '{32'h000001FF, ovf_val(32'h000001FF), 1'b1};

    reset = 1'b1; clr_count = 1'b0;
    bus.in_valid = 1'b1; bus.din = 32'h12345678; bus.out_ready = 1'b1;
    step(); step();
    reset = 1'b0; bus.in_valid = 1'b0;
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset dout", {24'd0, bus.dout}, 32'd0);
    chk("reset out_ovf", {31'd0, bus.out_ovf}, 32'd0);
    chk("reset ovf_count", {16'd0, ovf_count}, 32'd0);

    // Streaming table, one word per cycle with the consumer always ready
    exp_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1'b1; bus.din = vecs[i].din;
      step();
      exp_cnt += int'(vecs[i].exp_ovf);
      chk($sformatf("vec%0d out_valid", i), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("vec%0d dout", i), {24'd0, bus.dout}, {24'd0, vecs[i].exp_dout});
      chk($sformatf("vec%0d out_ovf", i), {31'd0, bus.out_ovf}, {31'd0, vecs[i].exp_ovf});
      chk($sformatf("vec%0d ovf_count", i), {16'd0, ovf_count}, exp_cnt);
    end
    bus.in_valid = 1'b0;
    step();
    chk("drain out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("drain dout held", {24'd0, bus.dout}, {24'd0, vecs[8].exp_dout});

    // Backpressure: third word must stall, then all three drain in order
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.din = 32'h01;
    step();
    chk("bp first in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.din = 32'h02;
    step();
    chk("bp full in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.din = 32'h03;
    step();
    chk("bp stalled in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp stable dout", {24'd0, bus.dout}, 32'h01);
    bus.out_ready = 1'b1;
    step();
    chk("bp pop1 dout", {24'd0, bus.dout}, 32'h02);
    chk("bp pop1 in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk("bp pop2 dout", {24'd0, bus.dout}, 32'h03);
    bus.in_valid = 1'b0;
    step();
    chk("bp empty out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("bp ovf_count", {16'd0, ovf_count}, 32'd5);

    // Mid-operation reset with a full FIFO
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.din = 32'h11;
    step();
    bus.din = 32'h22;
    step();
    chk("full in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("full ovf_count", {16'd0, ovf_count}, 32'd5);
    reset = 1'b1; bus.din = 32'h00000100; bus.out_ready = 1'b1;
    step();
    reset = 1'b0; bus.in_valid = 1'b0;
    chk("midreset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midreset in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("midreset ovf_count", {16'd0, ovf_count}, 32'd0);

    // Clear beats a same-cycle overflow increment
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.din = 32'h00000100; clr_count = 1'b1;
    step();
    chk("clr ovf_count", {16'd0, ovf_count}, 32'd0);
    chk("clr out_ovf", {31'd0, bus.out_ovf}, 32'd1);
    clr_count = 1'b0; bus.din = 32'hFFFF0000;
    step();
    chk("after clr ovf_count", {16'd0, ovf_count}, 32'd1);
    chk("after clr dout", {24'd0, bus.dout}, {24'd0, ovf_val(32'hFFFF0000)});
    bus.in_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
